rom_fetch_seq: RTL

Read sequencer placed directly in front of the single-port block ROM (`MEM_WIDTH`-wide, `MEM_DEPTH`-deep, one-cycle registered read with `enable`). On a start command it walks a contiguous window of ROM addresses and produces the ROM's enable and address. It captures each returned word and streams it downstream on a valid/ready interface. A small buffer absorbs the ROM's one-cycle latency so that a stalled consumer never loses a word.

---
 rtl/rom_fetch_pkg.sv | 13 +
 rtl/rom_fetch_seq_if.sv | 45 ++++
 rtl/rom_fetch_fifo.sv | 63 ++++++
 rtl/rom_fetch_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the ROM fetch sequencer and its output buffer.
package rom_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int FETCH_FIFO_DEPTH = 4;
    localparam int FETCH_FIFO_CW    = $clog2(FETCH_FIFO_DEPTH) + 1;

endpackage

// File: rtl/rom_fetch_seq_if.sv
// Control, ROM-side and stream-side signals of the ROM fetch sequencer.
// The descend input exists only when ROM_FETCH_DESCEND_EN is defined.
interface rom_fetch_seq_if #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 1024
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [AW:0]          count;
`ifdef ROM_FETCH_DESCEND_EN
    logic                 descend;
`endif
    logic                 busy;
    logic                 done;
    logic                 rom_enable;
    logic [AW-1:0]        rom_address;
    logic [MEM_WIDTH-1:0] rom_dout;
    logic                 out_valid;
    logic                 out_ready;
    logic [MEM_WIDTH-1:0] out_data;
    logic [AW:0]          out_index;

`ifdef ROM_FETCH_DESCEND_EN
    modport master (
        input  start, base_addr, count, descend, rom_dout, out_ready,
        output busy, done, rom_enable, rom_address, out_valid, out_data, out_index
    );
    modport slave (
        output start, base_addr, count, descend, rom_dout, out_ready,
        input  busy, done, rom_enable, rom_address, out_valid, out_data, out_index
    );
`else
    modport master (
        input  start, base_addr, count, rom_dout, out_ready,
        output busy, done, rom_enable, rom_address, out_valid, out_data, out_index
    );
    modport slave (
        output start, base_addr, count, rom_dout, out_ready,
        input  busy, done, rom_enable, rom_address, out_valid, out_data, out_index
    );
`endif

endinterface

// File: rtl/rom_fetch_fifo.sv
// Small synchronous FIFO holding {index, data} pairs returned by the ROM.
// Push and pop in the same cycle are allowed even when full.
module rom_fetch_fifo
    import rom_fetch_pkg::*;
#(
    parameter int DW = 43
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [DW-1:0]            i_din,
    input  logic                     i_pop,
    output logic [DW-1:0]            o_dout,
    output logic [FETCH_FIFO_CW-1:0] o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int PW = $clog2(FETCH_FIFO_DEPTH);

    logic [DW-1:0]            r_mem [FETCH_FIFO_DEPTH];
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [FETCH_FIFO_CW-1:0] r_count;
    logic                     w_push;
    logic                     w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FETCH_FIFO_CW'(FETCH_FIFO_DEPTH));
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // Qualify requests so an empty pop or overflowing push is never performed.
    always_comb begin
        w_pop  = i_pop && !o_empty;
        w_push = i_push && (!o_full || w_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FETCH_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FETCH_FIFO_CW'(1);
                2'b01:   r_count <= r_count - FETCH_FIFO_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rom_fetch_seq.sv
// Walks a window of ROM addresses and streams the returned words on valid/ready.
// Define ROM_FETCH_DESCEND_EN to add descending address walks.
module rom_fetch_seq
    import rom_fetch_pkg::*;
#(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic             clock,
    input  logic             reset,
    rom_fetch_seq_if.master  bus
);
    localparam int            AW        = $clog2(MEM_DEPTH);
    localparam int            IW        = AW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

    fetch_state_t             r_state;
    fetch_state_t             w_state_nxt;
    logic [AW-1:0]            r_addr;
    logic [AW-1:0]            w_addr_nxt;
    logic [IW-1:0]            r_count;
    logic [IW-1:0]            r_issue_idx;
    logic [IW-1:0]            r_infl_idx;
    logic                     r_inflight;
    logic                     r_busy;
    logic                     r_done;
`ifdef ROM_FETCH_DESCEND_EN
    logic                     r_descend;
`endif
    logic                     w_issue;
    logic                     w_last_issue;
    logic                     w_pop;
    logic                     w_last_pop;
    logic                     w_load;
    logic                     w_done_nxt;
    logic                     w_credit_ok;
    logic [FETCH_FIFO_CW-1:0] w_fifo_count;
    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic [IW+MEM_WIDTH-1:0]  w_fifo_dout;

    rom_fetch_fifo #(.DW(IW + MEM_WIDTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_din   ({r_infl_idx, bus.rom_dout}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // The in-flight read already owns a FIFO slot, so it counts against credit.
    assign w_credit_ok = (w_fifo_count + FETCH_FIFO_CW'(r_inflight)) < FETCH_FIFO_CW'(FETCH_FIFO_DEPTH);

    // Issue, accept and next-address decisions.
    always_comb begin
        w_issue      = (r_state == FETCH) && (r_issue_idx < r_count) && w_credit_ok && !w_fifo_full;
        w_last_issue = w_issue && ((r_issue_idx + IW'(1)) == r_count);
        w_pop        = !w_fifo_empty && bus.out_ready;
        w_last_pop   = w_pop && ((w_fifo_dout[IW+MEM_WIDTH-1:MEM_WIDTH] + IW'(1)) == r_count);
`ifdef ROM_FETCH_DESCEND_EN
        if (r_descend) begin
            w_addr_nxt = (r_addr == '0) ? LAST_ADDR : r_addr - AW'(1);
        end else begin
            w_addr_nxt = (r_addr == LAST_ADDR) ? '0 : r_addr + AW'(1);
        end
`else
        w_addr_nxt = (r_addr == LAST_ADDR) ? '0 : r_addr + AW'(1);
`endif
    end

    // Next-state logic of the run FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    if (bus.count == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = FETCH;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FETCH: begin
                if (w_last_issue) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (w_last_pop) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run context, address walker, in-flight tracking and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr      <= '0;
            r_count     <= '0;
            r_issue_idx <= '0;
            r_infl_idx  <= '0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef ROM_FETCH_DESCEND_EN
            r_descend   <= 1'b0;
`endif
        end else begin
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= w_done_nxt;
            r_inflight <= w_issue;
            if (w_load) begin
                r_addr      <= bus.base_addr;
                r_count     <= bus.count;
                r_issue_idx <= '0;
`ifdef ROM_FETCH_DESCEND_EN
                r_descend   <= bus.descend;
`endif
            end else if (w_issue) begin
                r_addr      <= w_addr_nxt;
                r_issue_idx <= r_issue_idx + IW'(1);
            end
            if (w_issue) begin
                r_infl_idx <= r_issue_idx;
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.rom_enable  = w_issue;
    assign bus.rom_address = r_addr;
    assign bus.out_valid   = !w_fifo_empty;
    assign bus.out_index   = w_fifo_dout[IW+MEM_WIDTH-1:MEM_WIDTH];
    assign bus.out_data    = w_fifo_dout[MEM_WIDTH-1:0];

endmodule
